// File: rtl/tmds_mode_switcher.sv
// tmds_mode_switcher: glitch-free switch between several TMDS timing-mode
// sources. A switch waits for the frame start of the old mode, then for the
// frame start of the new mode, and when muting is enabled it also holds a
// few muted frames before the new mode goes out.
//
// Build option: define TMDS_SWITCH_MUTE_EN to send the TMDS control symbol
// on every channel while the new mode settles. When it is undefined, the
// old mode's words stay on tmds_out until the new mode's first frame start.
//
// state    | meaning
// ---------+------------------------------------------------------------
// LOCKED   | outputs follow active_mode, no switch pending
// WAIT_OLD | switch requested, waiting for frame start of the old mode
// WAIT_NEW | active_mode = target, waiting for frame start of the target
// SETTLE   | muted, counting target frame starts up to SETTLE_FRAMES

module tmds_mode_switcher #(
    parameter int NUM_MODES     = 2,
    parameter int NUM_CHANNELS  = 3,
    parameter int SETTLE_FRAMES = 2,
    parameter int MW            = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                              clk_pixel,
    input  logic                              reset_n,
    input  logic [MW-1:0]                     mode_sel,
    input  logic [NUM_MODES*NUM_CHANNELS*10-1:0] tmds_in,
    input  logic [NUM_MODES*11-1:0]           cx_in,
    input  logic [NUM_MODES*10-1:0]           cy_in,
    output logic [NUM_CHANNELS*10-1:0]        tmds_out,
    output logic [10:0]                       cx,
    output logic [9:0]                        cy,
    output logic [MW-1:0]                     active_mode,
    output logic                              switching,
    output logic                              mode_changed
);

    localparam int         CW        = NUM_CHANNELS * 10;
    localparam logic [9:0] CTRL_SYM  = 10'b1101010100;
    localparam logic [3:0] SETTLE_TC = 4'(SETTLE_FRAMES);
`ifdef TMDS_SWITCH_MUTE_EN
    localparam bit MUTE_EN = 1'b1;
`else
    localparam bit MUTE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        WAIT_OLD = 2'd1,
        WAIT_NEW = 2'd2,
        SETTLE   = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [MW-1:0]       target, target_n;
    logic [MW-1:0]       active_n;
    logic [MW-1:0]       shown_mode, shown_n;
    logic [3:0]          frame_cnt, frame_cnt_n;
    logic                pulse_n;
    logic                mute_n;
    logic                sel_valid;
    logic [(1<<MW)-1:0]  frame_start;
    logic [CW-1:0]       mute_word;

    assign mute_word = {NUM_CHANNELS{CTRL_SYM}};
    assign sel_valid = (int'(mode_sel) < NUM_MODES);

    // Per-mode frame start: both position counters at zero (level condition).
    always_comb begin
        frame_start = '0;
        for (int m = 0; m < NUM_MODES; m++) begin
            frame_start[m] = (cx_in[m*11 +: 11] == 11'd0) && (cy_in[m*10 +: 10] == 10'd0);
        end
    end

    // Next-state decision; outputs are registered from these next values so
    // every output reflects the same state in the same cycle.
    always_comb begin
        state_n     = state;
        target_n    = target;
        active_n    = active_mode;
        frame_cnt_n = frame_cnt;
        pulse_n     = 1'b0;
        case (state)
            LOCKED: begin
                if (sel_valid && (mode_sel != active_mode)) begin
                    target_n = mode_sel;
                    state_n  = WAIT_OLD;
                end
            end
            WAIT_OLD: begin
                if (sel_valid && (mode_sel == active_mode)) begin
                    // Request withdrawn before anything changed on the link.
                    target_n = mode_sel;
                    state_n  = LOCKED;
                end else begin
                    if (sel_valid) target_n = mode_sel;
                    if (frame_start[active_mode]) begin
                        active_n = target_n;
                        state_n  = WAIT_NEW;
                    end
                end
            end
            WAIT_NEW, SETTLE: begin
                if (sel_valid && (mode_sel != target)) begin
                    target_n    = mode_sel;
                    active_n    = mode_sel;
                    frame_cnt_n = 4'd0;
                    state_n     = WAIT_NEW;
                end else if (frame_start[active_mode]) begin
                    if (state == WAIT_NEW) begin
                        frame_cnt_n = 4'd0;
                        if (MUTE_EN) begin
                            state_n = SETTLE;
                        end else begin
                            state_n = LOCKED;
                            pulse_n = 1'b1;
                        end
                    end else begin
                        frame_cnt_n = (frame_cnt == 4'hF) ? 4'hF : frame_cnt + 4'd1;
                        if (frame_cnt_n >= SETTLE_TC) begin
                            state_n = LOCKED;
                            pulse_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = LOCKED;
        endcase
    end

    // Without muting, tmds_out keeps the previously shown mode until the new
    // mode reaches its own frame start; cx/cy always track active_mode.
    always_comb begin
        mute_n  = MUTE_EN && ((state_n == WAIT_NEW) || (state_n == SETTLE));
        shown_n = ((state_n == WAIT_NEW) || (state_n == SETTLE)) ? shown_mode : active_n;
    end

    // State and registered outputs.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state        <= LOCKED;
            target       <= '0;
            active_mode  <= '0;
            shown_mode   <= '0;
            frame_cnt    <= 4'd0;
            tmds_out     <= mute_word;
            cx           <= 11'd0;
            cy           <= 10'd0;
            switching    <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_n;
            target       <= target_n;
            active_mode  <= active_n;
            shown_mode   <= shown_n;
            frame_cnt    <= frame_cnt_n;
            tmds_out     <= mute_n ? mute_word : tmds_in[int'(shown_n)*CW +: CW];
            cx           <= cx_in[int'(active_n)*11 +: 11];
            cy           <= cy_in[int'(active_n)*10 +: 10];
            switching    <= (state_n != LOCKED);
            mode_changed <= pulse_n;
        end
    end

endmodule

// File: tb/tb_tmds_mode_switcher.sv
// Randomized self-checking bench for tmds_mode_switcher (3 modes, 3 channels,
// 2 settle frames). A frame-level reference model predicts every output.

module tb_tmds_mode_switcher;

    localparam int NM = 3;
    localparam int NC = 3;
    localparam int SF = 2;
    localparam int MW = 2;
    localparam logic [9:0] CTRL = 10'b1101010100;
`ifdef TMDS_SWITCH_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif
    localparam int P_LOCK = 0, P_WOLD = 1, P_WNEW = 2, P_SETT = 3;

    logic                  clk_pixel;
    logic                  reset_n;
    logic [MW-1:0]         mode_sel;
    logic [NM*NC*10-1:0]   tmds_in;
    logic [NM*11-1:0]      cx_in;
    logic [NM*10-1:0]      cy_in;
    logic [NC*10-1:0]      tmds_out;
    logic [10:0]           cx;
    logic [9:0]            cy;
    logic [MW-1:0]         active_mode;
    logic                  switching;
    logic                  mode_changed;

    tmds_mode_switcher #(
        .NUM_MODES(NM), .NUM_CHANNELS(NC), .SETTLE_FRAMES(SF)
    ) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .mode_sel(mode_sel),
        .tmds_in(tmds_in), .cx_in(cx_in), .cy_in(cy_in),
        .tmds_out(tmds_out), .cx(cx), .cy(cy), .active_mode(active_mode),
        .switching(switching), .mode_changed(mode_changed)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    // Stimulus sources: each mode runs its own small raster.
    int         hc [NM];
    int         vc [NM];
    logic [9:0] word [NM][NC];
    int         sel;
    bit         rnd;

    // Reference model (frame-level view of a switch).
    int ph, act, tgt, cnt, shown;
    bit pulse;
    logic [NC*10-1:0] exp_tmds;
    int exp_cx, exp_cy, exp_act;
    bit exp_sw, exp_mc;

    int errors, checks, dut_pulses, mute_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int hmax(input int m); return 6 + 2*m; endfunction
    function automatic int vmax(input int m); return 3 + m; endfunction

    task automatic set_expect();
        exp_act = act;
        exp_sw  = (ph != P_LOCK);
        exp_mc  = pulse;
        exp_cx  = hc[act];
        exp_cy  = vc[act];
        for (int c = 0; c < NC; c++)
            exp_tmds[c*10 +: 10] = (MUTE && ph >= P_WNEW) ? CTRL : word[shown][c];
    endtask

    task automatic model_reset();
        ph = P_LOCK; act = 0; tgt = 0; cnt = 0; shown = 0; pulse = 1'b0;
        exp_act = 0; exp_sw = 1'b0; exp_mc = 1'b0; exp_cx = 0; exp_cy = 0;
        exp_tmds = {NC{CTRL}};
    endtask

    task automatic model_step();
        bit fs [NM];
        bit valid;
        for (int m = 0; m < NM; m++) fs[m] = (hc[m] == 0) && (vc[m] == 0);
        valid = (sel < NM);
        pulse = 1'b0;
        case (ph)
            P_LOCK: if (valid && sel != act) begin tgt = sel; ph = P_WOLD; end
            P_WOLD: begin
                if (valid && sel == act) begin
                    tgt = act; ph = P_LOCK;
                end else begin
                    if (valid) tgt = sel;
                    if (fs[act]) begin act = tgt; ph = P_WNEW; end
                end
            end
            default: begin
                if (valid && sel != tgt) begin
                    tgt = sel; act = sel; cnt = 0; ph = P_WNEW;
                end else if (fs[act]) begin
                    if (ph == P_WNEW) begin
                        cnt = 0;
                        if (MUTE) ph = P_SETT;
                        else begin ph = P_LOCK; pulse = 1'b1; end
                    end else begin
                        if (cnt < 15) cnt++;
                        if (cnt >= SF) begin ph = P_LOCK; pulse = 1'b1; end
                    end
                end
            end
        endcase
        if (ph == P_LOCK || ph == P_WOLD) shown = act;
        set_expect();
    endtask

    task automatic drive();
        for (int m = 0; m < NM; m++) begin
            for (int c = 0; c < NC; c++) tmds_in[(m*NC+c)*10 +: 10] = word[m][c];
            cx_in[m*11 +: 11] = 11'(hc[m]);
            cy_in[m*10 +: 10] = 10'(vc[m]);
        end
        mode_sel = MW'(sel);
    endtask

    task automatic drive_step();
        for (int m = 0; m < NM; m++) begin
            if (!(rnd && $urandom_range(0, 7) == 0)) begin
                hc[m]++;
                if (hc[m] == hmax(m)) begin
                    hc[m] = 0;
                    vc[m]++;
                    if (vc[m] == vmax(m)) vc[m] = 0;
                end
            end
        end
        if (rnd)
            for (int m = 0; m < NM; m++)
                for (int c = 0; c < NC; c++) word[m][c] = 10'($urandom);
        drive();
        model_step();
    endtask

    task automatic compare_outputs();
        check_val("tmds_out", tmds_out, exp_tmds);
        check_val("cx", cx, exp_cx);
        check_val("cy", cy, exp_cy);
        check_val("active_mode", active_mode, exp_act);
        check_val("switching", switching, exp_sw);
        check_val("mode_changed", mode_changed, exp_mc);
        if (mode_changed === 1'b1) dut_pulses++;
        if (tmds_out[9:0] === CTRL) mute_seen++;
    endtask

    task automatic tick();
        @(negedge clk_pixel);
        compare_outputs();
        drive_step();
    endtask

    task automatic run_until_phase(input int p, input int maxc, input string tag);
        int n;
        n = 0;
        while (ph != p && n < maxc) begin tick(); n++; end
        check_val(tag, 32'(ph == p), 32'd1);
    endtask

    task automatic const_words();
        for (int c = 0; c < NC; c++) begin
            word[0][c] = 10'h155;
            word[1][c] = 10'h2AA;
            word[2][c] = 10'h0F3;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog @%0t: bench did not finish", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        errors = 0; checks = 0; dut_pulses = 0; mute_seen = 0;
        rnd = 1'b0; sel = 0;
        for (int m = 0; m < NM; m++) begin hc[m] = m + 2; vc[m] = 1; end
        const_words();
        reset_n = 1'b0;
        drive();
        model_reset();
        @(negedge clk_pixel);
        compare_outputs();
        reset_n = 1'b1;
        drive_step();

        // Locked on mode 0.
        repeat (10) tick();

        // Switch 0 -> 1 mid-frame.
        sel = 1; dut_pulses = 0;
        repeat (160) tick();
        check_val("pulses_0to1", dut_pulses, 1);
        check_val("active_after_0to1", active_mode, 1);

        // Request withdrawn inside WAIT_OLD.
        n = 0;
        while (!(hc[1] == 1 && vc[1] == 0) && n < 64) begin tick(); n++; end
        sel = 0; tick();
        sel = 1; dut_pulses = 0; mute_seen = 0;
        repeat (60) tick();
        check_val("pulses_withdrawn", dut_pulses, 0);
        check_val("mute_withdrawn", mute_seen, 0);
        check_val("active_withdrawn", active_mode, 1);

        // Retarget 1 -> 2 while the switch to 1 is still settling.
        sel = 0;
        repeat (160) tick();
        sel = 1;
        run_until_phase(MUTE ? P_SETT : P_WNEW, 200, "reach_settle_1");
        sel = 2; dut_pulses = 0;
        repeat (250) tick();
        check_val("pulses_retarget", dut_pulses, 1);
        check_val("active_retarget", active_mode, 2);

        // Out-of-range request is ignored.
        sel = 3;
        repeat (40) tick();
        check_val("active_invalid", active_mode, 2);
        check_val("switching_invalid", switching, 0);

        // Asynchronous reset in the middle of a switch.
        sel = 0;
        repeat (160) tick();
        sel = 1;
        run_until_phase(MUTE ? P_SETT : P_WNEW, 200, "reach_settle_2");
        repeat (3) tick();
        @(negedge clk_pixel);
        compare_outputs();
        #2 reset_n = 1'b0;
        #1 model_reset();
        compare_outputs();
        @(negedge clk_pixel);
        compare_outputs();
        reset_n = 1'b1;
        sel = 0; dut_pulses = 0;
        drive_step();
        repeat (20) tick();
        check_val("pulses_after_reset", dut_pulses, 0);
        check_val("active_after_reset", active_mode, 0);

        // Random traffic: random words, stalled rasters, random requests.
        rnd = 1'b1;
        repeat (1500) begin
            if ($urandom_range(0, 15) == 0) sel = $urandom_range(0, 3);
            tick();
        end
        @(negedge clk_pixel);
        compare_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
